raw_capture_ctrl: RTL and testbench

- Capture controller that consumes the 32-bit software trigger register word (already in user_clk domain) and writes a burst of raw ADC samples into a snapshot BRAM.
- Arms on a rising edge of the software arm bit, optionally waits for the system sync pulse, then streams DATA_W-bit samples into consecutive BRAM addresses.
- Exports a 32-bit status word back to a simulink2ppc register for software polling.

---
 rtl/raw_capture_pkg.sv | 39 +++
 rtl/capture_addr_counter.sv | 36 +++
 rtl/raw_capture_ctrl.sv | 152 +++++++++++++++
 tb/tb_raw_capture_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_capture_pkg.sv
// Shared definitions for the raw ADC snapshot capture controller.
//   - cap_state_e   : capture FSM states
//   - *_BIT / LEN_* : field positions in the software trigger word
//   - STAT_*_BIT    : field positions in the software status word
//   - calc_eff_len  : maps the requested length onto the usable capture depth
package raw_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_e;

   // trig_reg fields
   localparam int unsigned ARM_BIT       = 0;
   localparam int unsigned WAIT_SYNC_BIT = 1;
   localparam int unsigned ABORT_BIT     = 2;
   localparam int unsigned LEN_LSB       = 16;
   localparam int unsigned LEN_MSB       = 31;

   // status fields; words_written occupies [ADDR_W:0]
   localparam int unsigned STAT_DONE_BIT  = 31;
   localparam int unsigned STAT_BUSY_BIT  = 30;
   localparam int unsigned STAT_ARMED_BIT = 29;
   localparam int unsigned STAT_OVF_BIT   = 28;

   // A length of zero, or one beyond the BRAM, means "fill the whole BRAM".
   function automatic logic [31:0] calc_eff_len(input logic [15:0] len,
                                                input logic [31:0] depth);
      logic [31:0] len_ext;
      len_ext = {16'd0, len};
      if (len == 16'd0 || len_ext > depth) begin
         return depth;
      end
      return len_ext;
   endfunction

endpackage

// File: rtl/capture_addr_counter.sv
// Write-address / words-written counter for the capture controller.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear (start of a new run), wins over en
//   en         : advance by one (one BRAM write accepted)
//   eff_len    : effective capture length, 1..2^ADDR_W
//   count      : number of words written so far (ADDR_W+1 bits)
//   last       : count is at eff_len-1, i.e. the next write is the final one
module capture_addr_counter #(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [ADDR_W:0]   eff_len,
   output logic [ADDR_W:0]   count,
   output logic              last
);

   logic [ADDR_W:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + (ADDR_W + 1)'(1);
      end
   end

   assign count = count_q;
   assign last  = (count_q == eff_len - (ADDR_W + 1)'(1));

endmodule

// File: rtl/raw_capture_ctrl.sv
// Raw ADC snapshot capture controller.
// Arms on a rising edge of the software arm bit, optionally waits for the
// system sync pulse, then writes eff_len valid samples into consecutive BRAM
// addresses starting at 0. Reports progress through a 32-bit status word.
// Ports:
//   user_clk, user_rst_n : capture clock, asynchronous active-low reset
//   trig_reg             : software trigger word {length, -, abort, wait_sync, arm}
//   sync_in              : one-cycle system sync pulse
//   din, din_vld         : raw sample stream and its qualifier
//   bram_addr/data/we    : registered BRAM write port
//   status               : {done, busy, armed, overflow_len, ..., words_written}
module raw_capture_ctrl
   import raw_capture_pkg::*;
#(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 64
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic [31:0]       trig_reg,
   input  logic              sync_in,
   input  logic [DATA_W-1:0] din,
   input  logic              din_vld,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_data,
   output logic              bram_we,
   output logic [31:0]       status
);

   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   cap_state_e        state_q, state_d;
   logic              arm_q;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [31:0]       status_q, status_d;
   logic [ADDR_W:0]   eff_len_q;
   logic              ovf_q;

   logic              arm_edge, arm_go, abort;
   logic              lat_en, cnt_clr, cnt_en;
   logic [31:0]       len_ext, eff_len_full;
   logic [ADDR_W:0]   eff_len_new;
   logic              len_ovf;
   logic [ADDR_W:0]   count;
   logic              last;
   logic              unused_bits;

   // Field decode
   assign abort        = trig_reg[ABORT_BIT];
   assign arm_edge     = trig_reg[ARM_BIT] & ~arm_q;
   assign arm_go       = arm_edge & ~abort;   // abort suppresses a simultaneous arm
   assign len_ext      = {16'd0, trig_reg[LEN_MSB:LEN_LSB]};
   assign len_ovf      = (len_ext > DEPTH);
   assign eff_len_full = calc_eff_len(trig_reg[LEN_MSB:LEN_LSB], DEPTH);
   assign eff_len_new  = eff_len_full[ADDR_W:0];
   assign unused_bits  = ^{trig_reg[LEN_LSB-1:ABORT_BIT+1], eff_len_full[31:ADDR_W+1]};

   capture_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_addr_counter (
      .clk     (user_clk),
      .rst_n   (user_rst_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .eff_len (eff_len_q),
      .count   (count),
      .last    (last)
   );

   // Next-state and write-port logic
   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      lat_en  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (arm_go) begin
               lat_en  = 1'b1;
               cnt_clr = 1'b1;
               state_d = trig_reg[WAIT_SYNC_BIT] ? ARMED : CAPTURE;
            end
         end
         ARMED: begin
            // The sample that arrives alongside sync is deliberately dropped.
            if (abort) begin
               state_d = IDLE;
            end else if (sync_in) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (din_vld) begin
               we_d    = 1'b1;
               addr_d  = count[ADDR_W-1:0];
               data_d  = din;
               cnt_en  = 1'b1;
               if (last) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      status_d                 = '0;
      status_d[STAT_DONE_BIT]  = (state_q == DONE);
      status_d[STAT_BUSY_BIT]  = (state_q == CAPTURE);
      status_d[STAT_ARMED_BIT] = (state_q == ARMED);
      status_d[STAT_OVF_BIT]   = ovf_q;
      status_d[ADDR_W:0]       = count;
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q   <= IDLE;
         arm_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         status_q  <= '0;
         eff_len_q <= (ADDR_W + 1)'(DEPTH);
         ovf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         arm_q    <= trig_reg[ARM_BIT];
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         status_q <= status_d;
         if (lat_en) begin
            eff_len_q <= eff_len_new;
            ovf_q     <= len_ovf;
         end
      end
   end

   assign bram_we   = we_q;
   assign bram_addr = addr_q;
   assign bram_data = data_q;
   assign status    = status_q;

endmodule

// File: tb/tb_raw_capture_ctrl.sv
// Scoreboard bench for raw_capture_ctrl (ADDR_W=4, DATA_W=64).
// The stimulus process pushes each expected BRAM write into a queue; a
// monitor pops and compares on every cycle the DUT asserts bram_we.
module tb_raw_capture_ctrl;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 64;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk;
   logic              rst_n;
   logic [31:0]       trig_reg;
   logic              sync_in;
   logic [DATA_W-1:0] din;
   logic              din_vld;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_data;
   logic              bram_we;
   logic [31:0]       status;

   wr_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   raw_capture_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .trig_reg   (trig_reg),
      .sync_in    (sync_in),
      .din        (din),
      .din_vld    (din_vld),
      .bram_addr  (bram_addr),
      .bram_data  (bram_data),
      .bram_we    (bram_we),
      .status     (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every write the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && bram_we) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write actual addr=%0d data=%0h required none",
                     bram_addr, bram_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bram_addr !== e.addr || bram_data !== e.data) begin
               bad++;
               $display("FAIL write actual addr=%0d data=%0h required addr=%0d data=%0h",
                        bram_addr, bram_data, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Drive one sample for one cycle; optionally expect it at address a.
   task automatic sample(input logic vld, input logic [63:0] d, input logic expect_wr,
                         input logic [ADDR_W-1:0] a);
      wr_t e;
      din     = d;
      din_vld = vld;
      if (expect_wr) begin
         e.addr = a;
         e.data = d;
         exp_q.push_back(e);
      end
      tick();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic arm(input logic [31:0] word);
      din_vld  = 1'b0;
      trig_reg = 32'h0;
      tick();
      trig_reg = word;
      tick();
   endtask

   task automatic idle_cycles(input int n);
      din_vld = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int nwr;
      logic vld_pat [7];
      vld_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_n    = 1'b0;
      trig_reg = 32'h0;
      sync_in  = 1'b0;
      din      = '0;
      din_vld  = 1'b0;
      tick();
      tick();
      check("reset_status", 64'(status), 64'h0);
      check("reset_we", 64'(bram_we), 64'h0);
      check("reset_addr", 64'(bram_addr), 64'h0);
      check("reset_data", bram_data, 64'h0);
      rst_n = 1'b1;
      tick();

      // Immediate capture, length 8
      arm(32'h0008_0001);
      for (int i = 0; i < 8; i++) sample(1'b1, 64'(i), 1'b1, ADDR_W'(i));
      sample(1'b1, 64'h99, 1'b0, '0);
      idle_cycles(2);
      drain("imm_drain");
      check("imm_status", 64'(status), 64'h8000_0008);
      check("imm_we_low", 64'(bram_we), 64'h0);

      // Sync wait, length 4
      arm(32'h0004_0003);
      for (int i = 0; i < 20; i++) sample(1'b1, 64'h50 + 64'(i), 1'b0, '0);
      check("sync_armed_status", 64'(status), 64'h2000_0000);
      sync_in = 1'b1;
      sample(1'b1, 64'hAA, 1'b0, '0);
      sync_in = 1'b0;
      for (int i = 0; i < 4; i++) sample(1'b1, 64'h100 + 64'(i), 1'b1, ADDR_W'(i));
      idle_cycles(2);
      drain("sync_drain");
      check("sync_status", 64'(status), 64'h8000_0004);

      // Gapped valid, length 4
      arm(32'h0004_0001);
      nwr = 0;
      for (int i = 0; i < 7; i++) begin
         if (vld_pat[i]) begin
            sample(1'b1, 64'h10 + 64'(i), 1'b1, ADDR_W'(nwr));
            nwr++;
         end else begin
            sample(1'b0, 64'hEE, 1'b0, '0);
            check("gap_addr_hold", 64'(bram_addr), 64'(nwr - 1));
            check("gap_we_low", 64'(bram_we), 64'h0);
         end
      end
      idle_cycles(2);
      drain("gap_drain");
      check("gap_status", 64'(status), 64'h8000_0004);

      // Length zero -> full depth
      arm(32'h0000_0001);
      for (int i = 0; i < 16; i++) sample(1'b1, 64'h200 + 64'(i), 1'b1, ADDR_W'(i));
      sample(1'b1, 64'h2FF, 1'b0, '0);
      idle_cycles(2);
      drain("len0_drain");
      check("len0_status", 64'(status), 64'h8000_0010);

      // Length beyond depth -> full depth plus overflow flag
      arm(32'h0020_0001);
      for (int i = 0; i < 16; i++) sample(1'b1, 64'h300 + 64'(i), 1'b1, ADDR_W'(i));
      sample(1'b1, 64'h3FF, 1'b0, '0);
      idle_cycles(2);
      drain("ovf_drain");
      check("ovf_status", 64'(status), 64'h9000_0010);

      // Abort after 5 writes
      arm(32'h0010_0001);
      for (int i = 0; i < 5; i++) sample(1'b1, 64'h400 + 64'(i), 1'b1, ADDR_W'(i));
      trig_reg = 32'h0010_0005;
      sample(1'b1, 64'h4AA, 1'b0, '0);
      check("abort_we_low", 64'(bram_we), 64'h0);
      for (int i = 0; i < 4; i++) sample(1'b1, 64'h4B0 + 64'(i), 1'b0, '0);
      drain("abort_drain");
      check("abort_status", 64'(status), 64'h0000_0005);

      // Abort together with an arm edge: arm ignored
      arm(32'h0010_0005);
      for (int i = 0; i < 4; i++) sample(1'b1, 64'h4C0 + 64'(i), 1'b0, '0);
      drain("abort_arm_drain");
      check("abort_arm_status", 64'(status), 64'h0000_0005);

      // Re-arm: full capture from address 0
      arm(32'h0010_0001);
      for (int i = 0; i < 16; i++) sample(1'b1, 64'h500 + 64'(i), 1'b1, ADDR_W'(i));
      idle_cycles(2);
      drain("rearm_drain");
      check("rearm_status", 64'(status), 64'h8000_0010);

      // Reset in the middle of a capture
      arm(32'h0008_0001);
      for (int i = 0; i < 3; i++) sample(1'b1, 64'h600 + 64'(i), 1'b1, ADDR_W'(i));
      din     = 64'h603;
      din_vld = 1'b1;
      @(negedge clk);
      #1;
      check("rst_pre_we", 64'(bram_we), 64'h1);
      rst_n = 1'b0;
      #1;
      check("rst_we_async", 64'(bram_we), 64'h0);
      check("rst_status_async", 64'(status), 64'h0);
      check("rst_addr_async", 64'(bram_addr), 64'h0);
      trig_reg = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) sample(1'b1, 64'h6A0 + 64'(i), 1'b0, '0);
      drain("rst_drain");
      check("rst_idle_status", 64'(status), 64'h0);
      arm(32'h0008_0001);
      for (int i = 0; i < 8; i++) sample(1'b1, 64'h700 + 64'(i), 1'b1, ADDR_W'(i));
      idle_cycles(2);
      drain("post_rst_drain");
      check("post_rst_status", 64'(status), 64'h8000_0008);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
